memory_read_responder: RTL
==========================

MEMORY_READ_RESPONDER -- requirements
Module: memory_read_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 32768, meaning the number of 16-bit words stored (64KB).
REQ-002 The module SHALL have parameter LATENCY, default 4, meaning the clock cycles from read acceptance to data_valid; legal range 1..8.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port enable  input  1  request strobe, sampled every cycle.
REQ-006 The module SHALL have port wr  input  1  request type when enable=1: 1 is write, 0 is read.
REQ-007 The module SHALL have port addr  input  16  byte address; bit 0 is ignored and the word index is addr[15:1].
REQ-008 The module SHALL have port data_in  input  16  write data.
REQ-009 The module SHALL have port data_out  output  16  read data, qualified by data_valid.
REQ-010 The module SHALL have port data_valid  output  1  high for exactly one cycle per returned read.
REQ-011 The module SHALL have port pending  output  4  count of reads accepted but not yet returned.
REQ-012 The module SHALL have port addr_err  output  1  out-of-range flag, present only under MEM_ADDR_ERR_EN.

Function
REQ-013 The module SHALL accept one request every cycle in which enable=1, with no backpressure.
REQ-014 A write (enable=1, wr=1) SHALL update mem[addr[15:1]] with data_in at the accepting edge.
REQ-015 A write SHALL produce no data_valid pulse.
REQ-016 A read (enable=1, wr=0) accepted at edge T SHALL sample mem[addr[15:1]] at edge T.
REQ-017 The sampled read data SHALL travel through a LATENCY-deep valid/data shift pipeline.
REQ-018 The read SHALL be presented with data_valid=1 for the cycle following edge T+LATENCY-1, so data_valid rises exactly LATENCY cycles after the request cycle.
REQ-019 Back-to-back reads SHALL return in order, one per cycle, with no bubbles.
REQ-020 A write at edge T SHALL be visible to a read accepted at edge T+1 or later.
REQ-021 A read accepted at edge T SHALL return the pre-write value when the same word is written at any edge after T while that read is in flight.
REQ-022 data_out SHALL hold its last valid value while data_valid=0.
REQ-023 pending SHALL increment on each read acceptance and decrement on each data_valid cycle.
REQ-024 When a read acceptance and a data_valid occur in the same cycle, pending SHALL stay unchanged.
REQ-025 pending SHALL never exceed LATENCY and SHALL never wrap.
REQ-026 If DEPTH_WORDS < 32768, a write whose word index >= DEPTH_WORDS SHALL be discarded.
REQ-027 If DEPTH_WORDS < 32768, a read whose word index >= DEPTH_WORDS SHALL return 16'h0000.
REQ-028 Memory contents SHALL NOT be initialised by reset; the bench SHALL write every word before reading it.

Reset
REQ-029 While rst_n=0, all in-flight reads SHALL be discarded immediately.
REQ-030 While rst_n=0, data_valid SHALL be 0, data_out 16'h0000, pending 0 and addr_err 0.
REQ-031 Memory contents SHALL be retained across reset.
REQ-032 Requests presented while rst_n=0 SHALL be ignored.
REQ-033 A read issued on the first edge after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-034 With macro MEM_ADDR_ERR_EN defined, port addr_err SHALL exist.
REQ-035 With MEM_ADDR_ERR_EN defined, addr_err SHALL pulse high together with data_valid for a read that was out of range at acceptance.
REQ-036 With MEM_ADDR_ERR_EN defined, addr_err SHALL pulse high one cycle after acceptance of an out-of-range write.
REQ-037 With MEM_ADDR_ERR_EN undefined, the port and its logic SHALL be absent, and out-of-range behaviour SHALL remain per REQ-026 and REQ-027.

Verification
REQ-038 Write 16'hBEEF to addr 16'h0010, then read 16'h0010 next cycle -> data_valid high exactly 4 cycles after the read, data_out=16'hBEEF, pending 1 then 0.
REQ-039 Eight consecutive reads of addr 0x0000,0x0002,...,0x000E preloaded with 0..7 -> eight consecutive data_valid cycles returning 0..7 in order, pending peaks at 4.
REQ-040 Read addr 16'h0020 (holding 16'h1111), then write 16'h2222 there on the next cycle -> the read returns 16'h1111, and a later read returns 16'h2222.
REQ-041 Reads of 16'h0005 and 16'h0004 after writing 16'hA5A5 to 16'h0004 -> both return 16'hA5A5.
REQ-042 Issue 3 reads, then assert rst_n=0 for one cycle mid-flight -> no data_valid for those reads, pending=0, and a read issued immediately after reset returns correctly.
REQ-043 With DEPTH_WORDS=1024 and MEM_ADDR_ERR_EN defined, read addr 16'h0800 -> data_out=16'h0000 with addr_err=1 on the data_valid cycle.

Source files
------------

// File: rtl/memory_read_responder.sv
// Word-addressed 16-bit memory with a fixed-latency, in-order read return pipeline.
// Optional MEM_ADDR_ERR_EN adds the addr_err out-of-range flag.
module memory_read_responder #(
  parameter int DEPTH_WORDS = 32768,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  pending
`ifdef MEM_ADDR_ERR_EN
  ,
  output logic        addr_err
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [15:0] mem [DEPTH_WORDS];
  logic [14:0] idx;
  logic        in_range;
  logic        rd_acc;
  logic        wr_acc;
  logic [15:0] rd_word;
  logic        unused_addr_lsb;

  assign idx             = addr[15:1];
  assign unused_addr_lsb = addr[0];
  assign rd_acc          = enable & ~wr;
  assign wr_acc          = enable & wr & in_range;

  generate
    if (DEPTH_WORDS >= 32768) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = ({17'd0, idx} < 32'(DEPTH_WORDS));
    end
  endgenerate

  assign rd_word = in_range ? mem[idx[AW-1:0]] : 16'h0000;

  // Memory is deliberately not reset so its contents survive rst_n pulses.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[idx[AW-1:0]] <= data_in;
    end
  end

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] vld_in;
  logic [15:0]        dat    [LATENCY];
  logic [15:0]        dat_in [LATENCY];

  generate
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign vld_in[0] = rd_acc;
        assign dat_in[0] = rd_word;
      end else begin : g_body
        assign vld_in[i] = vld[i-1];
        assign dat_in[i] = dat[i-1];
      end
    end
  endgenerate

  // The last stage only loads on a valid entry, which gives the data_out hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld <= vld_in;
      for (int i = 0; i < LATENCY - 1; i++) dat[i] <= dat_in[i];
      if (vld_in[LATENCY-1]) dat[LATENCY-1] <= dat_in[LATENCY-1];
    end
  end

  assign data_out   = dat[LATENCY-1];
  assign data_valid = vld[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      case ({rd_acc, data_valid})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

`ifdef MEM_ADDR_ERR_EN
  logic [LATENCY-1:0] err;
  logic [LATENCY-1:0] err_in;
  logic               wr_err;

  generate
    for (genvar i = 0; i < LATENCY; i++) begin : g_err
      if (i == 0) begin : g_head
        assign err_in[0] = rd_acc & ~in_range;
      end else begin : g_body
        assign err_in[i] = err[i-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err    <= '0;
      wr_err <= 1'b0;
    end else begin
      err    <= err_in;
      wr_err <= enable & wr & ~in_range;
    end
  end

  assign addr_err = (err[LATENCY-1] & vld[LATENCY-1]) | wr_err;
`endif

endmodule
